// File: rtl/work_queue_if.sv
// Bundle between the processor core and work_queue: push port, pop request/grant,
// and per-FIFO status. The core side uses master, work_queue uses slave.
interface work_queue_if #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned PC_W       = 16
);
    logic                  queue_wen;
    logic [3:0]            queue_number;
    logic [PC_W-1:0]       queue_pc;
    logic                  request_new_pc;
    logic [PC_W-1:0]       new_pc;
    logic                  new_pc_valid;
    logic                  busy;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] full;
    logic                  overflow;
    logic                  bad_queue;

    modport master (
        output queue_wen, queue_number, queue_pc, request_new_pc,
        input  new_pc, new_pc_valid, busy, empty, full, overflow, bad_queue
    );

    modport slave (
        input  queue_wen, queue_number, queue_pc, request_new_pc,
        output new_pc, new_pc_valid, busy, empty, full, overflow, bad_queue
    );
endinterface

// File: rtl/work_queue.sv
// Bank of PC FIFOs beside the processor core; pushes come from the core, pops are
// served one per request in round-robin order starting at rr.
module work_queue #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PC_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    work_queue_if.slave   bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned QW    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    logic [1:0]            state;
    logic [QW-1:0]         rr;
    logic [QW-1:0]         pick;
    logic                  found;
    logic                  do_pop;
    logic                  num_valid;
    logic [PC_W-1:0]       head;
    int unsigned           idx;

    logic [PC_W-1:0]       mem    [NUM_QUEUES][DEPTH];
    logic [PTR_W-1:0]      rd_ptr [NUM_QUEUES];
    logic [PTR_W-1:0]      wr_ptr [NUM_QUEUES];
    logic [CNT_W-1:0]      cnt    [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] num_hit;
    logic [NUM_QUEUES-1:0] push_ok;
    logic [NUM_QUEUES-1:0] pop_sel;

    // Fullness is judged on pre-edge count, so a push to a full FIFO is dropped
    // even when the same FIFO is popped in that cycle.
    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_flags
        assign num_hit[g]   = (bus.queue_number == 4'(g));
        assign push_ok[g]   = bus.queue_wen && num_hit[g] && (cnt[g] != CNT_W'(DEPTH));
        assign pop_sel[g]   = do_pop && (pick == QW'(g));
        assign bus.empty[g] = (cnt[g] == '0);
        assign bus.full[g]  = (cnt[g] == CNT_W'(DEPTH));
    end

    assign num_valid = |num_hit;

    // First non-empty FIFO at or after rr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
            idx = 32'(rr) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            if (!found && cnt[QW'(idx)] != '0) begin
                found = 1'b1;
                pick  = QW'(idx);
            end
        end
    end

    assign do_pop           = (state == WAIT) && found;
    assign head             = mem[pick][rd_ptr[pick]];
    assign bus.new_pc_valid = (state == GRANT);
    assign bus.busy         = (state == WAIT);

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            if (push_ok[QW'(i)]) mem[QW'(i)][wr_ptr[QW'(i)]] <= bus.queue_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                rd_ptr[QW'(i)] <= '0;
                wr_ptr[QW'(i)] <= '0;
                cnt[QW'(i)]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                if (push_ok[QW'(i)])
                    wr_ptr[QW'(i)] <= (wr_ptr[QW'(i)] == PTR_W'(DEPTH - 1)) ? '0
                                      : wr_ptr[QW'(i)] + PTR_W'(1);
                if (pop_sel[QW'(i)])
                    rd_ptr[QW'(i)] <= (rd_ptr[QW'(i)] == PTR_W'(DEPTH - 1)) ? '0
                                      : rd_ptr[QW'(i)] + PTR_W'(1);
                if (push_ok[QW'(i)] && !pop_sel[QW'(i)])
                    cnt[QW'(i)] <= cnt[QW'(i)] + CNT_W'(1);
                else if (!push_ok[QW'(i)] && pop_sel[QW'(i)])
                    cnt[QW'(i)] <= cnt[QW'(i)] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr            <= '0;
            bus.new_pc    <= '0;
            bus.overflow  <= 1'b0;
            bus.bad_queue <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.request_new_pc) state <= WAIT;
                WAIT:    if (found) state <= GRANT;
                GRANT:   state <= IDLE;
                default: state <= IDLE;
            endcase
            if (do_pop) begin
                bus.new_pc <= head;
                rr         <= (pick == QW'(NUM_QUEUES - 1)) ? '0 : pick + QW'(1);
            end
            if (bus.queue_wen && !num_valid) bus.bad_queue <= 1'b1;
            if (bus.queue_wen && num_valid && push_ok == '0) bus.overflow <= 1'b1;
        end
    end
endmodule
